// File: rtl/logic_gate_pkg.sv
// Shared types for the logic-gate arbiter: opcode encoding, FSM states and
// the opcode legality helper.
package logic_gate_pkg;

    typedef enum logic [3:0] {
        OP_AND    = 4'd0,
        OP_OR     = 4'd1,
        OP_NOT_A  = 4'd2,
        OP_NOT_B  = 4'd3,
        OP_XOR    = 4'd4,
        OP_XNOR   = 4'd5,
        OP_BUF_A  = 4'd6,
        OP_BUF_B  = 4'd7,
        OP_NAND   = 4'd8,
        OP_NOR    = 4'd9
    } op_e;

    localparam int NUM_OPS = 10;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_e;

    function automatic logic op_legal(input logic [3:0] op);
        return op < 4'(NUM_OPS);
    endfunction

endpackage

// File: rtl/logic_gate_arbiter_if.sv
// Request/response channels between the requester agents and the arbiter.
interface logic_gate_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [4*NUM_REQ-1:0] req_op;
    logic [NUM_REQ-1:0]   req_a;
    logic [NUM_REQ-1:0]   req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic                 rsp_data;
    logic                 rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping; the pointer itself is owned by the caller.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 found
);
    localparam int IDX_W = $clog2(N);

    int cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr) + k) % N;
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
        if (found) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/logic_gate_arbiter.sv
// Round-robin front end for one shared logic-gate unit: one operation in
// flight, result returned tagged with the requester id.
module logic_gate_arbiter
    import logic_gate_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int GATE_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    logic_gate_arbiter_if.slave bus,
    output logic                gate_a,
    output logic                gate_b,
    input  logic [NUM_OPS-1:0]  gate_res,
    output logic                busy
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int LAT_W = (GATE_LAT > 1) ? $clog2(GATE_LAT) : 1;

    state_e               state;
    state_e               state_nxt;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      grant_idx;
    logic [NUM_REQ-1:0]   grant;
    logic                 found;
    logic [LAT_W-1:0]     lat_cnt;
    logic [3:0]           op_q;
    logic [3:0]           sel_op;
    logic                 take;
    logic                 capture;
    logic [NUM_REQ-1:0]   ready_raw;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx),
        .found (found)
    );

    assign sel_op = bus.req_op[4*grant_idx +: 4];

    always_comb begin
        state_nxt = state;
        ready_raw = '0;
        take      = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    ready_raw = grant;
                    take      = 1'b1;
                    state_nxt = op_legal(sel_op) ? EXEC : RESP;
                end
            end
            EXEC: begin
                if (lat_cnt == LAT_W'(GATE_LAT - 1)) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Gate the grant with rst so nothing is accepted while reset is held.
    assign bus.req_ready = rst ? '0 : ready_raw;
    assign bus.rsp_valid = (state == RESP);
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            lat_cnt      <= '0;
            op_q         <= '0;
            gate_a       <= 1'b0;
            gate_b       <= 1'b0;
            bus.rsp_id   <= '0;
            bus.rsp_data <= 1'b0;
            bus.rsp_err  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == EXEC) begin
                lat_cnt <= lat_cnt + 1'b1;
            end
            if (take) begin
                bus.rsp_id <= grant_idx;
                op_q       <= sel_op;
                gate_a     <= bus.req_a[grant_idx];
                gate_b     <= bus.req_b[grant_idx];
                lat_cnt    <= '0;
                rr_ptr     <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                if (!op_legal(sel_op)) begin
                    bus.rsp_err  <= 1'b1;
                    bus.rsp_data <= 1'b0;
                end
            end
            if (capture) begin
                bus.rsp_data <= gate_res[op_q];
                bus.rsp_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_logic_gate_arbiter.sv
// Scoreboard bench: two arbiter instances (gate latency 1 and 3) sharing one
// stimulus path, selected by sel; a negedge monitor checks every response.
module tb_logic_gate_arbiter;
    import logic_gate_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic_gate_arbiter_if #(.NUM_REQ(N)) ia ();
    logic_gate_arbiter_if #(.NUM_REQ(N)) ib ();

    logic         sel = 1'b0;
    logic [N-1:0] valid = '0;
    logic [N-1:0] a_v = '0;
    logic [N-1:0] b_v = '0;
    logic [4*N-1:0] op_v = '0;
    logic         rdy = 1'b1;

    logic gate_a_a, gate_b_a, gate_a_b, gate_b_b, busy_a, busy_b;
    logic [9:0] res_a, res_b_s1, res_b_s2;

    assign ia.req_valid = sel ? '0 : valid;
    assign ib.req_valid = sel ? valid : '0;
    assign ia.req_op = op_v;
    assign ib.req_op = op_v;
    assign ia.req_a = a_v;
    assign ib.req_a = a_v;
    assign ia.req_b = b_v;
    assign ib.req_b = b_v;
    assign ia.rsp_ready = rdy;
    assign ib.rsp_ready = rdy;

    wire [N-1:0] ready = sel ? ib.req_ready : ia.req_ready;
    wire         rv    = sel ? ib.rsp_valid : ia.rsp_valid;
    wire [1:0]   rid   = sel ? ib.rsp_id    : ia.rsp_id;
    wire         rdat  = sel ? ib.rsp_data  : ia.rsp_data;
    wire         rerr  = sel ? ib.rsp_err   : ia.rsp_err;

    function automatic logic ref_gate(input int op, input logic a, input logic b);
        case (op)
            0: return a & b;
            1: return a | b;
            2: return ~a;
            3: return ~b;
            4: return a ^ b;
            5: return ~(a ^ b);
            6: return a;
            7: return b;
            8: return ~(a & b);
            9: return ~(a | b);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [9:0] gate_vec(input logic a, input logic b);
        logic [9:0] v;
        for (int i = 0; i < 10; i++) v[i] = ref_gate(i, a, b);
        return v;
    endfunction

    // Gate unit stubs: instant for instance a, two register stages for b.
    assign res_a = gate_vec(gate_a_a, gate_b_a);
    always @(posedge clk) begin
        res_b_s1 <= gate_vec(gate_a_b, gate_b_b);
        res_b_s2 <= res_b_s1;
    end

    logic_gate_arbiter #(.NUM_REQ(N), .GATE_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .bus(ia),
        .gate_a(gate_a_a), .gate_b(gate_b_a), .gate_res(res_a), .busy(busy_a)
    );

    logic_gate_arbiter #(.NUM_REQ(N), .GATE_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .bus(ib),
        .gate_a(gate_a_b), .gate_b(gate_b_b), .gate_res(res_b_s2), .busy(busy_b)
    );

    typedef struct {
        int   id;
        logic data;
        logic err;
        int   due;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    int first_cyc = 0;
    bit seen = 1'b0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (rv && !seen) begin
                seen = 1'b1;
                first_cyc = cyc;
            end
            if (rv && rdy) begin
                seen = 1'b0;
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp actual_id=%0d required=none", rid);
                end else begin
                    e = q.pop_front();
                    chk("rsp_id", 32'(rid), 32'(e.id));
                    chk("rsp_data", 32'(rdat), 32'(e.data));
                    chk("rsp_err", 32'(rerr), 32'(e.err));
                    chk("rsp_latency", 32'(first_cyc), 32'(e.due));
                end
            end
        end
    end

    task automatic push_exp(input int id, input logic data, input logic err, input int hs);
        exp_t e;
        e.id   = id;
        e.data = data;
        e.err  = err;
        e.due  = hs + (err ? 1 : (sel ? 4 : 2));
        q.push_back(e);
    endtask

    task automatic issue(input int id, input int op, input logic a, input logic b,
                         input logic data, input logic err, output int hs);
        int k;
        op_v[4*id +: 4] = 4'(op);
        a_v[id] = a;
        b_v[id] = b;
        valid[id] = 1'b1;
        hs = -1;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ready[id]) break;
        end
        if (!ready[id]) begin
            checks++;
            failures++;
            $display("FAIL grant_timeout req=%0d actual=none required=grant", id);
            valid[id] = 1'b0;
        end else begin
            hs = cyc;
            push_exp(id, data, err, hs);
            @(posedge clk);
            #1;
            valid[id] = 1'b0;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && q.size() != 0; k++) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain actual_pending=%0d required=0", q.size());
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : stim
        int hs;
        int acc;
        int k;
        logic [3:0] exp_d;

        // Reset values with all requesters asking.
        valid = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_rsp_valid", 32'(rv), 0);
        chk("rst_gate_ab", {gate_a_a, gate_b_a}, 0);
        chk("rst_rsp_id_data_err", {rid, rdat, rerr}, 0);
        chk("rst_req_ready", 32'(ready), 0);
        valid = '0;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Requester 2 XOR 1,0.
        issue(2, OP_XOR, 1'b1, 1'b0, 1'b1, 1'b0, hs);
        drain();

        // Illegal opcode from requester 1.
        issue(1, 12, 1'b1, 1'b1, 1'b0, 1'b1, hs);
        drain();

        // Response stalled; requester 0 waits behind it.
        rdy = 1'b0;
        issue(3, OP_AND, 1'b1, 1'b1, 1'b1, 1'b0, hs);
        op_v[3:0] = 4'(OP_OR);
        a_v[0] = 1'b0;
        b_v[0] = 1'b0;
        valid[0] = 1'b1;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rv) break;
        end
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk("stall_hold", {rv, rid, rdat, rerr, ready}, {1'b1, 2'd3, 1'b1, 1'b0, 4'b0000});
        end
        @(posedge clk);
        #1;
        rdy = 1'b1;
        acc = cyc;
        issue(0, OP_OR, 1'b0, 1'b0, 1'b0, 1'b0, hs);
        chk("grant_after_accept", 32'(hs), 32'(acc + 1));
        drain();

        // Reset while requester 1 is executing; the operation is dropped.
        op_v[7:4] = 4'(OP_AND);
        a_v[1] = 1'b1;
        b_v[1] = 1'b1;
        valid[1] = 1'b1;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ready[1]) break;
        end
        @(posedge clk);
        #1;
        valid = '0;
        chk("exec_busy", 32'(busy_a), 1);
        op_v = {4'(OP_NOT_A), 4'(OP_NAND), 4'(OP_OR), 4'(OP_XOR)};
        a_v = 4'b0101;
        b_v = 4'b0111;
        exp_d = 4'b1010;
        valid = 4'b1111;
        rst = 1'b1;
        #1;
        chk("midrst_busy_valid", {busy_a, rv}, 0);
        chk("midrst_gate_ab", {gate_a_a, gate_b_a}, 0);
        chk("midrst_id_data_err", {rid, rdat, rerr}, 0);
        @(negedge clk);
        chk("midrst_req_ready", 32'(ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // All four requesting continuously: round-robin from requester 0.
        for (int g = 0; g < 6; g++) begin
            for (k = 0; k < 50; k++) begin
                @(negedge clk);
                if (|ready) break;
            end
            chk("grant_onehot", 32'($countones(ready)), 1);
            chk("grant_order", 32'(ready), 32'(1 << (g % 4)));
            push_exp(g % 4, exp_d[g % 4], 1'b0, cyc);
        end
        @(posedge clk);
        #1;
        valid = '0;
        drain();

        // Full opcode/operand sweep on the three-cycle gate unit.
        sel = 1'b1;
        @(posedge clk);
        #1;
        for (int op = 0; op < 10; op++) begin
            for (int ab = 0; ab < 4; ab++) begin
                issue((op + ab) % 4, op, ab[1], ab[0], ref_gate(op, ab[1], ab[0]), 1'b0, hs);
            end
        end
        issue(2, 15, 1'b1, 1'b0, 1'b0, 1'b1, hs);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
